// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared types and constants for the branch resolution controller.
//   ctrl_state_t   : controller FSM states (RUN, FLUSH)
//   branch_entry_t : one in-flight predicted branch {pc, target, pred}
//   PC_STEP        : byte distance to the sequential (fall-through) PC
//   fallthrough_pc : PC of the instruction after a not-taken branch
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
    } branch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Wraps naturally at 2^32, so a branch at the top of the address
    // space falls through to address 0.
    function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/branch_queue.sv
// ---------------------------------------------------------------------------
// branch_queue
// Circular FIFO holding in-flight predicted branches in program order.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   push        : write push_entry at the tail
//   pop         : drop the head entry
//   clear       : empty the queue (wins over push and pop)
//   push_entry  : entry to be written
//   head_entry  : oldest entry (meaningful only when occupancy > 0)
//   occupancy   : number of entries held, 0..DEPTH
// The caller guarantees no push when full and no pop when empty.
// ---------------------------------------------------------------------------
module branch_queue
    import branch_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  branch_entry_t     push_entry,
    output branch_entry_t     head_entry,
    output logic [OCC_W-1:0]  occupancy
);

    branch_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // DEPTH is a power of two, so pointer increments wrap for free.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push && !clear && !reset) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    assign head_entry = mem[head_ptr];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
// Tracks predicted conditional branches from decode, checks the oldest one
// against its execute-stage outcome, trains the predictor and orders a
// flush/redirect with a front-end stall on a mispredict.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   alloc_valid/ready   : decode hands over one predicted branch
//   alloc_pc/target/pred: branch PC, taken target, issued prediction
//   res_valid/res_taken : execute resolves the oldest in-flight branch
//   pred_update_*       : one-cycle training pulse per resolved branch
//   flush, redirect_pc  : one-cycle flush pulse and fetch redirect address
//   stall               : front-end hold during recovery
//   occupancy           : branches currently in flight
//   mispredict_count    : mispredicts since reset (wraps)
// ---------------------------------------------------------------------------
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter  int DEPTH        = 4,
    parameter  int FLUSH_CYCLES = 2,
    localparam int OCC_W        = $clog2(DEPTH) + 1,
    localparam int CNT_W        = $clog2(FLUSH_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [31:0]       alloc_pc,
    input  logic [31:0]       alloc_target,
    input  logic              alloc_pred,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              pred_update_valid,
    output logic [31:0]       pred_update_pc,
    output logic              pred_update_taken,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic              stall,
    output logic [OCC_W-1:0]  occupancy,
    output logic [31:0]       mispredict_count
);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] flush_cnt_next;
    logic             run_en;
    branch_entry_t    head_entry;
    branch_entry_t    push_entry;
    logic             alloc_fire;
    logic             resolve_fire;
    logic             mispredict;

    // Ready depends only on registers; run_en keeps it low while reset is
    // held and through the first cycle in which reset is sampled low.
    assign alloc_ready  = run_en && (state == RUN) && (occupancy < OCC_W'(DEPTH));
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign resolve_fire = (state == RUN) && res_valid && (occupancy != '0);
    assign mispredict   = resolve_fire && (res_taken != head_entry.pred);
    assign stall        = (state == FLUSH);

    assign push_entry = '{pc: alloc_pc, target: alloc_target, pred: alloc_pred};

    // A mispredict clears the queue, which also drops a same-cycle alloc.
    branch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (alloc_fire),
        .pop        (resolve_fire),
        .clear      (mispredict),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .occupancy  (occupancy)
    );

    // FLUSH lasts FLUSH_CYCLES cycles counting the flush cycle itself, so
    // the counter is loaded with FLUSH_CYCLES-1 and leaves when it hits 0.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    state_next     = FLUSH;
                    flush_cnt_next = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next     = RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            run_en    <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            run_en    <= 1'b1;
        end
    end

    // Training, flush and redirect are registered: they appear the cycle
    // after the resolve. PC/taken/redirect hold their last value when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_update_valid <= 1'b0;
            pred_update_pc    <= '0;
            pred_update_taken <= 1'b0;
            flush             <= 1'b0;
            redirect_pc       <= '0;
            mispredict_count  <= '0;
        end else begin
            pred_update_valid <= resolve_fire;
            flush             <= mispredict;
            if (resolve_fire) begin
                pred_update_pc    <= head_entry.pc;
                pred_update_taken <= res_taken;
            end
            if (mispredict) begin
                redirect_pc      <= res_taken ? head_entry.target
                                              : fallthrough_pc(head_entry.pc);
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Directed plus short random stimulus for branch_resolve_ctrl. A small
// behavioural model of the in-flight queue and recovery window predicts
// every output; predictor training pulses are scoreboarded through a queue.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int OCC_W        = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [31:0]      alloc_pc;
    logic [31:0]      alloc_target;
    logic             alloc_pred;
    logic             res_valid;
    logic             res_taken;
    logic             pred_update_valid;
    logic [31:0]      pred_update_pc;
    logic             pred_update_taken;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             stall;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      mispredict_count;

    branch_resolve_ctrl #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_pc          (alloc_pc),
        .alloc_target      (alloc_target),
        .alloc_pred        (alloc_pred),
        .res_valid         (res_valid),
        .res_taken         (res_taken),
        .pred_update_valid (pred_update_valid),
        .pred_update_pc    (pred_update_pc),
        .pred_update_taken (pred_update_taken),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .stall             (stall),
        .occupancy         (occupancy),
        .mispredict_count  (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
    } m_entry_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } upd_t;

    // Model state
    m_entry_t    m_q[$];
    upd_t        exp_q[$];
    int          m_flush_left;
    logic        m_run_en;
    logic        m_flush;
    logic [31:0] m_redirect;
    logic [31:0] m_count;
    logic [31:0] m_last_pc;
    logic        m_last_taken;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic exp_ready;
        logic exp_v;
        upd_t u;
        exp_ready = m_run_en && (m_flush_left == 0) && (m_q.size() < DEPTH);
        check32("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
        check32("flush", 32'(flush), 32'(m_flush));
        check32("redirect_pc", redirect_pc, m_redirect);
        check32("stall", 32'(stall), 32'(m_flush_left > 0));
        check32("occupancy", 32'(occupancy), 32'(m_q.size()));
        check32("mispredict_count", mispredict_count, m_count);
        exp_v = (exp_q.size() != 0);
        check32("pred_update_valid", 32'(pred_update_valid), 32'(exp_v));
        if (exp_v) begin
            u = exp_q.pop_front();
            m_last_pc    = u.pc;
            m_last_taken = u.taken;
        end
        check32("pred_update_pc", pred_update_pc, m_last_pc);
        check32("pred_update_taken", 32'(pred_update_taken), 32'(m_last_taken));
    endtask

    task automatic doReset(input int cycles);
        reset       = 1'b1;
        alloc_valid = 1'b0;
        alloc_pc    = '0;
        alloc_target = '0;
        alloc_pred  = 1'b0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            m_q.delete();
            exp_q.delete();
            m_flush_left = 0;
            m_run_en     = 1'b0;
            m_flush      = 1'b0;
            m_redirect   = '0;
            m_count      = '0;
            m_last_pc    = '0;
            m_last_taken = 1'b0;
            @(posedge clk);
            #1;
            checkOutput();
        end
        reset = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic av, input logic [31:0] apc, input logic [31:0] atgt,
                                 input logic apred, input logic rv, input logic rt);
        logic     ready;
        logic     misp;
        m_entry_t h;
        reset        = 1'b0;
        alloc_valid  = av;
        alloc_pc     = apc;
        alloc_target = atgt;
        alloc_pred   = apred;
        res_valid    = rv;
        res_taken    = rt;

        ready = m_run_en && (m_flush_left == 0) && (m_q.size() < DEPTH);
        misp  = 1'b0;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (rv && m_q.size() > 0) begin
            h = m_q.pop_front();
            exp_q.push_back('{pc: h.pc, taken: rt});
            if (rt != h.pred) begin
                misp         = 1'b1;
                m_redirect   = rt ? h.tgt : h.pc + 32'd4;
                m_count      = m_count + 32'd1;
                m_q.delete();
                m_flush_left = FLUSH_CYCLES;
            end
        end
        if (av && ready && !misp) begin
            m_q.push_back('{pc: apc, tgt: atgt, pred: apred});
        end
        m_flush  = misp;
        m_run_en = 1'b1;

        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held two cycles, then ready comes up
        doReset(2);
        idle(1);

        // Correct not-taken prediction
        applyStimulus(1'b1, 32'h100, 32'h180, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Mispredicted as not-taken: redirect to target
        applyStimulus(1'b1, 32'h200, 32'h400, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Mispredicted as taken at top of address space: fall-through wraps
        applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0000_0800, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Fill to DEPTH, fifth alloc held off, then overlapping alloc+resolve
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h10 + 32'(4 * i), 32'h1000, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h20, 32'h1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h20, 32'h1000, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        end
        idle(1);

        // Resolve with nothing in flight is ignored
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // Alloc in the mispredict cycle is discarded
        applyStimulus(1'b1, 32'h300, 32'h340, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h304, 32'h380, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Reset during the recovery window
        applyStimulus(1'b1, 32'h500, 32'h540, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        doReset(1);
        idle(2);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            logic [31:0] rpc;
            rpc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) begin
                rpc = 32'hFFFF_FFFC;
            end
            applyStimulus(1'($urandom_range(0, 1)), rpc, $urandom() & 32'hFFFF_FFFC,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end
        idle(4);

        check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
